sensor_channel_selector: RTL and testbench

- Parametrised successor to the single-bit sensor selector.
- Selects one bit of an N_CH-wide sensor enable bus, either by address (SINGLE mode) or by walking all channels (SCAN mode).
- SCAN mode emits one result per active channel, then reports how many were active.
- Sits between the sensor enable bus and the acquisition/report controller; uses a start/busy/valid/done handshake.

---
 rtl/sensor_sel_pkg.sv | 18 +
 rtl/sensor_channel_selector.sv | 154 +++++++++++++++
 tb/tb_sensor_channel_selector.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_sel_pkg.sv
// Shared types and defaults for the sensor channel selector.
// Also used by the acquisition controller for channel sizing.
package sensor_sel_pkg;

  localparam int N_CH_DEF   = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    SCAN = 2'd2,
    FIN  = 2'd3
  } sel_state_t;

endpackage

// File: rtl/sensor_channel_selector.sv
// Single-address or full-scan bit selector over a sensor enable bus.
// Optional SENSOR_SEL_MASK_EN adds a mask port applied at snapshot time.
module sensor_channel_selector
  import sensor_sel_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [N_CH-1:0]   enable,
`ifdef SENSOR_SEL_MASK_EN
  input  logic [N_CH-1:0]   mask,
`endif
  input  logic              abort,
  output logic              busy,
  output logic              valid,
  output logic              out_bit,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic              done,
  output logic [ADDR_W:0]   act_cnt
);

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(N_CH - 1);
  localparam logic [ADDR_W:0]   N_CH_W  = (ADDR_W + 1)'(N_CH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  sel_state_t state, state_n;

  logic [N_CH-1:0]   snap, snap_n, snap_in;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [ADDR_W:0]   cnt, cnt_n;

  logic              valid_n, out_bit_n, err_n, done_n;
  logic [ADDR_W-1:0] out_addr_n;
  logic [ADDR_W:0]   act_cnt_n;

  logic [N_CH-1:0]   sel_sh, scan_sh;
  logic              in_range;

`ifdef SENSOR_SEL_MASK_EN
  assign snap_in = enable & ~mask;
`else
  assign snap_in = enable;
`endif

  assign sel_sh   = snap >> addr_q;
  assign scan_sh  = snap >> idx;
  assign in_range = {1'b0, addr_q} < N_CH_W;

  always_comb begin
    state_n    = state;
    snap_n     = snap;
    addr_n     = addr_q;
    idx_n      = idx;
    cnt_n      = cnt;
    valid_n    = 1'b0;
    err_n      = 1'b0;
    done_n     = 1'b0;
    out_bit_n  = out_bit;
    out_addr_n = out_addr;
    act_cnt_n  = act_cnt;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          snap_n  = snap_in;
          addr_n  = addr;
          idx_n   = '0;
          cnt_n   = '0;
          state_n = (mode == MODE_SCAN) ? SCAN : SEL;
        end
      end
      SEL: begin
        valid_n    = 1'b1;
        out_addr_n = addr_q;
        if (in_range) begin
          out_bit_n = sel_sh[0];
        end else begin
          out_bit_n = 1'b0;
          err_n     = 1'b1;
        end
        cnt_n   = {{ADDR_W{1'b0}}, in_range & sel_sh[0]};
        state_n = FIN;
      end
      SCAN: begin
        if (scan_sh[0]) begin
          valid_n    = 1'b1;
          out_bit_n  = 1'b1;
          out_addr_n = idx;
          cnt_n      = cnt + CNT_ONE;
        end
        if (idx == LAST) begin
          state_n = FIN;
        end else begin
          idx_n = idx + IDX_ONE;
        end
      end
      FIN: begin
        done_n    = 1'b1;
        act_cnt_n = cnt;
        state_n   = IDLE;
      end
    endcase

    // Abort cancels everything scheduled for this edge.
    if (abort && state != IDLE) begin
      state_n    = IDLE;
      valid_n    = 1'b0;
      err_n      = 1'b0;
      done_n     = 1'b0;
      out_bit_n  = out_bit;
      out_addr_n = out_addr;
      act_cnt_n  = act_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      snap     <= '0;
      addr_q   <= '0;
      idx      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      out_bit  <= 1'b0;
      out_addr <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
      act_cnt  <= '0;
    end else begin
      state    <= state_n;
      snap     <= snap_n;
      addr_q   <= addr_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      busy     <= (state_n != IDLE);
      valid    <= valid_n;
      out_bit  <= out_bit_n;
      out_addr <= out_addr_n;
      err      <= err_n;
      done     <= done_n;
      act_cnt  <= act_cnt_n;
    end
  end

endmodule

// File: tb/tb_sensor_channel_selector.sv
// Randomized bench for sensor_channel_selector (N_CH=20, ADDR_W=5).
// Expected pulses come from a per-operation event table.
module tb_sensor_channel_selector;

  localparam int N  = 20;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [N-1:0]  enable = '0;
`ifdef SENSOR_SEL_MASK_EN
  logic [N-1:0]  mask = '0;
`endif
  logic          busy, valid, out_bit, err, done;
  logic [AW-1:0] out_addr;
  logic [AW:0]   act_cnt;

  int n_chk = 0;
  int n_err = 0;
  int exp_act = 0;

  always #5 clk = ~clk;

  sensor_channel_selector #(.N_CH(N), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .addr     (addr),
    .enable   (enable),
`ifdef SENSOR_SEL_MASK_EN
    .mask     (mask),
`endif
    .abort    (abort),
    .busy     (busy),
    .valid    (valid),
    .out_bit  (out_bit),
    .out_addr (out_addr),
    .err      (err),
    .done     (done),
    .act_cnt  (act_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".valid"}, int'(valid), 0);
    chk({tag, ".err"}, int'(err), 0);
    chk({tag, ".done"}, int'(done), 0);
    chk({tag, ".act"}, int'(act_cnt), exp_act);
  endtask

  // One operation: model builds the expected event table, then the
  // bench steps through it cycle by cycle.
  task automatic run_op(input logic m, input int a, input logic [N-1:0] en,
                        input int abort_at, input bit noise);
    logic [N-1:0] snap;
    int ev[N+2];
    int eb[N+2];
    int ea[N+2];
    int ee[N+2];
    int len;
    int cnt;
    snap = en;
`ifdef SENSOR_SEL_MASK_EN
    snap = en & ~mask;
`endif
    for (int t = 0; t < N + 2; t++) begin
      ev[t] = 0; eb[t] = 0; ea[t] = 0; ee[t] = 0;
    end
    cnt = 0;
    if (m == 1'b0) begin
      len   = 2;
      ev[1] = 1;
      ea[1] = a;
      if (a < N) eb[1] = int'(snap[a]);
      else ee[1] = 1;
      cnt = eb[1];
    end else begin
      len = N + 1;
      for (int i = 0; i < N; i++) begin
        if (snap[i]) begin
          ev[i+1] = 1; eb[i+1] = 1; ea[i+1] = i;
          cnt++;
        end
      end
    end

    mode   = m;
    addr   = AW'(a);
    enable = en;
    abort  = 1'b0;
    start  = 1'b1;
    tick();
    start = 1'b0;

    for (int t = 1; t <= len; t++) begin
      if (noise) begin
        enable = N'($urandom);
        start  = 1'($urandom);
        mode   = 1'($urandom);
        addr   = AW'($urandom);
`ifdef SENSOR_SEL_MASK_EN
        mask   = N'($urandom);
`endif
      end
      abort = (t == abort_at);
      tick();
      if (t == abort_at) begin
        chk_quiet("abort");
        break;
      end
      chk("valid", int'(valid), ev[t]);
      chk("err", int'(err), ee[t]);
      chk("done", int'(done), (t == len) ? 1 : 0);
      chk("busy", int'(busy), (t < len) ? 1 : 0);
      if (ev[t] != 0) begin
        chk("out_bit", int'(out_bit), eb[t]);
        chk("out_addr", int'(out_addr), ea[t]);
      end
      if (t == len) exp_act = cnt;
      chk("act_cnt", int'(act_cnt), exp_act);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic idle_cycle(input string tag);
    tick();
    chk_quiet(tag);
  endtask

  initial begin
    int a;
    int gap;
    logic m;
    logic [N-1:0] en;

    tick();
    tick();
    chk("rst.busy", int'(busy), 0);
    chk("rst.valid", int'(valid), 0);
    chk("rst.out_bit", int'(out_bit), 0);
    chk("rst.out_addr", int'(out_addr), 0);
    chk("rst.err", int'(err), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.act", int'(act_cnt), 0);
    rst = 1'b0;
    idle_cycle("post_rst");

    // SINGLE hit, miss, both address boundaries
    run_op(1'b0, 10, N'(32'h0000_0400), 0, 1'b0);
    idle_cycle("gap");
    run_op(1'b0, 11, N'(32'h0000_0400), 0, 1'b0);
    run_op(1'b0, 25, '1, 0, 1'b0);
    run_op(1'b0, 19, N'(32'h0008_0000), 0, 1'b1);
    run_op(1'b0, 20, '1, 0, 1'b0);
    run_op(1'b0, 0, N'(32'h0000_0001), 0, 1'b0);

    // SCAN: sparse, empty, full; noisy inputs during the scan
    run_op(1'b1, 0, N'(32'h0008_0005), 0, 1'b1);
    run_op(1'b1, 0, '0, 0, 1'b0);
    run_op(1'b1, 0, '1, 0, 1'b1);

    // Abort mid-scan keeps the previous count
    run_op(1'b1, 0, '1, 5, 1'b0);
    idle_cycle("after_abort");
    run_op(1'b0, 3, '1, 1, 1'b0);
    run_op(1'b0, 3, '0, 2, 1'b1);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    mode  = 1'b1;
    tick();
    chk_quiet("start_abort");
    start = 1'b0;
    abort = 1'b0;
    idle_cycle("start_abort2");

`ifdef SENSOR_SEL_MASK_EN
    mask = N'(32'h0000_03FF);
    run_op(1'b1, 0, '1, 0, 1'b0);
    mask = N'(32'h0000_03FF);
    run_op(1'b0, 4, '1, 0, 1'b0);
    mask = '0;
`endif

    for (int k = 0; k < 40; k++) begin
      m  = 1'($urandom);
      a  = int'($urandom_range(0, 31));
      en = N'($urandom);
`ifdef SENSOR_SEL_MASK_EN
      mask = N'($urandom);
`endif
      run_op(m, a, en,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0,
             1'($urandom));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) idle_cycle("rand_gap");
    end

    // Asynchronous reset in the middle of a scan
    run_op(1'b1, 0, '1, 0, 1'b0);
    mode   = 1'b1;
    enable = '1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    exp_act = 0;
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.valid", int'(valid), 0);
    chk("midrst.out_addr", int'(out_addr), 0);
    chk("midrst.out_bit", int'(out_bit), 0);
    chk("midrst.act", int'(act_cnt), 0);
    #1;
    rst = 1'b0;
    idle_cycle("midrst_idle");
    idle_cycle("midrst_idle2");
    run_op(1'b0, 2, N'(32'h0000_0004), 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
